// File: rtl/nios_core_ram_dma_pkg.sv
// Shared types and constants for the nios_core_ram_dma block-copy initiator.
// Optional fill mode is enabled by defining NIOS_CORE_RAM_DMA_FILL_EN.
package nios_core_ram_dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        DONE
    } state_e;

    localparam int MAX_READ_LATENCY = 4;
    localparam int LAT_W            = 3;

    // Low be_w bits set; callers truncate to their byteenable width.
    function automatic logic [63:0] be_ones(input int be_w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < be_w) r[i] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/nios_core_ram_dma.sv
// Avalon-MM initiator copying a block of words inside a word-addressed RAM slave.
// Define NIOS_CORE_RAM_DMA_FILL_EN to add pattern-fill commands (cmd_fill/cmd_pattern).
module nios_core_ram_dma
    import nios_core_ram_dma_pkg::*;
#(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_W-1:0]   cmd_src,
    input  logic [ADDR_W-1:0]   cmd_dst,
    input  logic [ADDR_W:0]     cmd_len,
`ifdef NIOS_CORE_RAM_DMA_FILL_EN
    input  logic                cmd_fill,
    input  logic [DATA_W-1:0]   cmd_pattern,
`endif
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   m_address,
    output logic [DATA_W/8-1:0] m_byteenable,
    output logic                m_chipselect,
    output logic                m_read,
    output logic                m_write,
    output logic [DATA_W-1:0]   m_writedata,
    input  logic [DATA_W-1:0]   m_readdata,
    input  logic                m_waitrequest
);

    localparam int                 BE_W     = DATA_W / 8;
    localparam logic [BE_W-1:0]    BE_ALL   = BE_W'(be_ones(BE_W));
    localparam logic [LAT_W-1:0]   LAT_INIT = LAT_W'(READ_LATENCY);
    localparam logic [LAT_W-1:0]   LAT_ONE  = LAT_W'(1);
    localparam logic [ADDR_W:0]    REM_ONE  = (ADDR_W+1)'(1);

    state_e              state_q;
    logic [ADDR_W-1:0]   src_q, dst_q;
    logic [ADDR_W:0]     rem_q;
    logic [LAT_W-1:0]    lat_q;
    logic                fill_q;
    logic                cmd_ready_q, busy_q, done_q;
    logic                cs_q, rd_q, wr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [BE_W-1:0]     be_q;
    logic [DATA_W-1:0]   wdata_q;

    logic                fill_d;
    logic [DATA_W-1:0]   pattern_d;
    logic [ADDR_W-1:0]   src_d, dst_d;

    always_comb begin
`ifdef NIOS_CORE_RAM_DMA_FILL_EN
        fill_d    = cmd_fill;
        pattern_d = cmd_pattern;
`else
        fill_d    = 1'b0;
        pattern_d = '0;
`endif
        // Pointers wrap naturally at 2^ADDR_W.
        src_d = src_q + 1'b1;
        dst_d = dst_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            rem_q       <= '0;
            lat_q       <= '0;
            fill_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cs_q        <= 1'b0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        src_q       <= cmd_src;
                        dst_q       <= cmd_dst;
                        rem_q       <= cmd_len;
                        fill_q      <= fill_d;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (cmd_len == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else if (fill_d) begin
                            state_q <= WR_REQ;
                            cs_q    <= 1'b1;
                            wr_q    <= 1'b1;
                            be_q    <= BE_ALL;
                            addr_q  <= cmd_dst;
                            wdata_q <= pattern_d;
                        end else begin
                            state_q <= RD_REQ;
                            cs_q    <= 1'b1;
                            rd_q    <= 1'b1;
                            be_q    <= BE_ALL;
                            addr_q  <= cmd_src;
                        end
                    end
                end
                RD_REQ: begin
                    if (!m_waitrequest) begin
                        state_q <= RD_WAIT;
                        lat_q   <= LAT_INIT;
                        cs_q    <= 1'b0;
                        rd_q    <= 1'b0;
                        be_q    <= '0;
                    end
                end
                RD_WAIT: begin
                    lat_q <= lat_q - 1'b1;
                    // wdata_q doubles as the word buffer between read and write.
                    if (lat_q == LAT_ONE) begin
                        state_q <= WR_REQ;
                        cs_q    <= 1'b1;
                        wr_q    <= 1'b1;
                        be_q    <= BE_ALL;
                        addr_q  <= dst_q;
                        wdata_q <= m_readdata;
                    end
                end
                WR_REQ: begin
                    if (!m_waitrequest) begin
                        src_q <= src_d;
                        dst_q <= dst_d;
                        rem_q <= rem_q - 1'b1;
                        if (rem_q == REM_ONE) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            cs_q    <= 1'b0;
                            wr_q    <= 1'b0;
                            be_q    <= '0;
                        end else if (fill_q) begin
                            addr_q <= dst_d;
                        end else begin
                            state_q <= RD_REQ;
                            wr_q    <= 1'b0;
                            rd_q    <= 1'b1;
                            addr_q  <= src_d;
                        end
                    end
                end
                DONE: begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign m_chipselect = cs_q;
    assign m_read       = rd_q;
    assign m_write      = wr_q;
    assign m_address    = addr_q;
    assign m_byteenable = be_q;
    assign m_writedata  = wdata_q;

endmodule
